// File: rtl/pc_redirect_if.sv
// Execute-stage control-transfer bus between the pipeline and the PC redirect unit.
interface pc_redirect_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             ex_valid;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_rs1;
    logic [31:0]      ex_imm_b;
    logic [31:0]      ex_imm_i;
    logic [31:0]      ex_imm_j;
    logic             br_eq;
    logic             br_lt;
    logic             br_ltu;
    logic             trap_ack;
    logic [31:0]      pc;
    logic             redirect;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             trap_misaligned;
    logic [31:0]      trap_tval;
    logic [CNT_W-1:0] br_total_cnt;
    logic [CNT_W-1:0] br_taken_cnt;

    modport master (
        output stall, ex_valid, ex_opcode, ex_funct3, ex_pc, ex_rs1,
               ex_imm_b, ex_imm_i, ex_imm_j, br_eq, br_lt, br_ltu, trap_ack,
        input  pc, redirect, flush_if_id, flush_id_ex, trap_misaligned,
               trap_tval, br_total_cnt, br_taken_cnt
    );

    modport slave (
        input  stall, ex_valid, ex_opcode, ex_funct3, ex_pc, ex_rs1,
               ex_imm_b, ex_imm_i, ex_imm_j, br_eq, br_lt, br_ltu, trap_ack,
        output pc, redirect, flush_if_id, flush_id_ex, trap_misaligned,
               trap_tval, br_total_cnt, br_taken_cnt
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// EX-stage branch/jump resolution: owns the fetch PC, raises redirect/flush,
// records misaligned-target traps and counts conditional branches.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    pc_redirect_if.slave    bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic        counted;  // conditional branch with a legal funct3
        logic        cond;     // branch condition met
        logic        taken;
        logic [31:0] target;
    } ex_dec_t;

    ex_dec_t dec;
    logic    misaligned;
    logic    redirect;

    always_comb begin
        dec        = '0;
        dec.target = bus.ex_pc + bus.ex_imm_b;
        case (bus.ex_opcode)
            OP_BRANCH: begin
                dec.target = bus.ex_pc + bus.ex_imm_b;
                dec.counted = 1'b1;
                case (bus.ex_funct3)
                    3'b000:  dec.cond = bus.br_eq;
                    3'b001:  dec.cond = !bus.br_eq;
                    3'b100:  dec.cond = bus.br_lt;
                    3'b101:  dec.cond = !bus.br_lt;
                    3'b110:  dec.cond = bus.br_ltu;
                    3'b111:  dec.cond = !bus.br_ltu;
                    default: dec.counted = 1'b0;
                endcase
                dec.taken = dec.counted && dec.cond;
            end
            OP_JAL: begin
                dec.target = bus.ex_pc + bus.ex_imm_j;
                dec.taken  = 1'b1;
            end
            OP_JALR: begin
                dec.target = (bus.ex_rs1 + bus.ex_imm_i) & 32'hFFFF_FFFE;
                dec.taken  = 1'b1;
            end
            default: ;
        endcase
    end

    // A taken transfer to a halfword-aligned target traps instead of redirecting.
    assign misaligned      = bus.ex_valid && dec.taken && dec.target[1];
    assign redirect        = bus.ex_valid && dec.taken && !dec.target[1];
    assign bus.redirect    = redirect;
    assign bus.flush_if_id = redirect;
    assign bus.flush_id_ex = redirect;

    logic [31:0] pc_q;
    assign bus.pc = pc_q;

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_VEC;
        else if (redirect)
            pc_q <= dec.target;
        else if (!bus.stall)
            pc_q <= pc_q + 32'd4;
    end

    logic        trap_q;
    logic [31:0] tval_q;
    assign bus.trap_misaligned = trap_q;
    assign bus.trap_tval       = tval_q;

    // First fault wins unless the pending record is being acknowledged this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
            tval_q <= '0;
        end else if (misaligned && (!trap_q || bus.trap_ack)) begin
            trap_q <= 1'b1;
            tval_q <= dec.target;
        end else if (bus.trap_ack) begin
            trap_q <= 1'b0;
            tval_q <= '0;
        end
    end

    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] taken_q;
    logic             count_en;
    assign count_en         = bus.ex_valid && dec.counted && !bus.stall;
    assign bus.br_total_cnt = total_q;
    assign bus.br_taken_cnt = taken_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
            taken_q <= '0;
        end else if (count_en) begin
            total_q <= total_q + 1'b1;
            if (dec.cond)
                taken_q <= taken_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed self-checking bench for pc_redirect_unit with hand-computed expectations.
module tb_pc_redirect_unit;
    localparam int CNT_W = 32;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    pc_redirect_if #(.CNT_W(CNT_W)) bus ();

    pc_redirect_unit #(.RESET_VEC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] epc, input logic [31:0] rs1);
        bus.ex_valid  = v;
        bus.ex_opcode = op;
        bus.ex_funct3 = f3;
        bus.ex_pc     = epc;
        bus.ex_rs1    = rs1;
    endtask

    task automatic check_flags(input string tag, input logic exp);
        #1;
        check({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, exp});
        check({tag, ".flush_if_id"}, {31'd0, bus.flush_if_id}, {31'd0, exp});
        check({tag, ".flush_id_ex"}, {31'd0, bus.flush_id_ex}, {31'd0, exp});
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] tot, input logic [31:0] tkn);
        check({tag, ".total"}, bus.br_total_cnt, tot);
        check({tag, ".taken"}, bus.br_taken_cnt, tkn);
    endtask

    initial begin
        bus.stall = 0; bus.trap_ack = 0;
        bus.br_eq = 0; bus.br_lt = 0; bus.br_ltu = 0;
        bus.ex_imm_b = 0; bus.ex_imm_i = 0; bus.ex_imm_j = 0;
        set_ex(0, 7'd0, 3'd0, 32'd0, 32'd0);

        // Reset and free-running fetch
        tick(); tick();
        check("rst.pc", bus.pc, 32'h0);
        check("rst.trap", {31'd0, bus.trap_misaligned}, 32'd0);
        check("rst.tval", bus.trap_tval, 32'h0);
        check_cnt("rst", 0, 0);
        check_flags("rst", 1'b0);
        rst = 0;
        tick(); check("idle.pc4", bus.pc, 32'h4);
        tick(); check("idle.pc8", bus.pc, 32'h8);
        tick(); check("idle.pc12", bus.pc, 32'hC);

        // beq taken / not taken
        set_ex(1, OP_BR, 3'b000, 32'h100, 32'h0);
        bus.ex_imm_b = 32'h20; bus.br_eq = 1;
        check_flags("beq_t", 1'b1);
        tick(); check("beq_t.pc", bus.pc, 32'h120); check_cnt("beq_t", 1, 1);
        bus.br_eq = 0;
        check_flags("beq_nt", 1'b0);
        tick(); check("beq_nt.pc", bus.pc, 32'h124); check_cnt("beq_nt", 2, 1);

        // bge / bltu / bgeu with lt=0, ltu=1
        bus.br_lt = 0; bus.br_ltu = 1;
        bus.ex_funct3 = 3'b101; check_flags("bge", 1'b1);
        tick(); check("bge.pc", bus.pc, 32'h120); check_cnt("bge", 3, 2);
        bus.ex_funct3 = 3'b110; check_flags("bltu", 1'b1);
        tick(); check("bltu.pc", bus.pc, 32'h120); check_cnt("bltu", 4, 3);
        bus.ex_funct3 = 3'b111; check_flags("bgeu", 1'b0);
        tick(); check("bgeu.pc", bus.pc, 32'h124); check_cnt("bgeu", 5, 3);

        // bne (eq=0) and blt (lt=1) taken
        bus.ex_funct3 = 3'b001; bus.br_eq = 0; check_flags("bne", 1'b1);
        tick(); check("bne.pc", bus.pc, 32'h120); check_cnt("bne", 6, 4);
        bus.ex_funct3 = 3'b100; bus.br_lt = 1; check_flags("blt", 1'b1);
        tick(); check("blt.pc", bus.pc, 32'h120); check_cnt("blt", 7, 5);
        bus.br_lt = 0;

        // Stalled taken branch still redirects but is not counted; stall alone holds pc
        bus.stall = 1; bus.ex_funct3 = 3'b110;
        check_flags("stall_br", 1'b1);
        tick(); check("stall_br.pc", bus.pc, 32'h120); check_cnt("stall_br", 7, 5);
        bus.ex_valid = 0;
        tick(); check("stall_hold.pc", bus.pc, 32'h120);
        bus.stall = 0;

        // JALR misaligned: trap, first fault wins, ack clears
        set_ex(1, OP_JALR, 3'b000, 32'h400, 32'h203); bus.ex_imm_i = 0;
        check_flags("jalr_mis", 1'b0);
        tick();
        check("jalr_mis.trap", {31'd0, bus.trap_misaligned}, 32'd1);
        check("jalr_mis.tval", bus.trap_tval, 32'h202);
        check("jalr_mis.pc", bus.pc, 32'h124);
        bus.ex_rs1 = 32'h306;
        tick();
        check("fault2.tval", bus.trap_tval, 32'h202);
        check("fault2.trap", {31'd0, bus.trap_misaligned}, 32'd1);
        bus.ex_valid = 0; bus.trap_ack = 1;
        tick();
        check("ack.trap", {31'd0, bus.trap_misaligned}, 32'd0);
        check("ack.tval", bus.trap_tval, 32'h0);
        bus.trap_ack = 0; bus.ex_valid = 1; bus.ex_rs1 = 32'h203;
        tick(); check("refault.tval", bus.trap_tval, 32'h202);
        bus.trap_ack = 1; bus.ex_rs1 = 32'h306;
        tick();
        check("ack_fault.trap", {31'd0, bus.trap_misaligned}, 32'd1);
        check("ack_fault.tval", bus.trap_tval, 32'h306);
        bus.ex_valid = 0;
        tick(); check("ack2.trap", {31'd0, bus.trap_misaligned}, 32'd0);
        bus.trap_ack = 0;

        // JALR aligned (bit 0 dropped) and JAL with address wrap
        set_ex(1, OP_JALR, 3'b000, 32'h500, 32'h1001); bus.ex_imm_i = 32'h3;
        check_flags("jalr_al", 1'b1);
        tick(); check("jalr_al.pc", bus.pc, 32'h1004);
        set_ex(1, OP_JAL, 3'b000, 32'hFFFF_FFF0, 32'h0); bus.ex_imm_j = 32'h20;
        check_flags("jal_wrap", 1'b1);
        tick(); check("jal_wrap.pc", bus.pc, 32'h10); check_cnt("jal_wrap", 7, 5);

        // Illegal funct3 and bubble
        set_ex(1, OP_BR, 3'b010, 32'h100, 32'h0); bus.br_eq = 1; bus.ex_imm_b = 32'h20;
        check_flags("f3_010", 1'b0);
        tick(); check("f3_010.pc", bus.pc, 32'h14); check_cnt("f3_010", 7, 5);
        set_ex(0, OP_BR, 3'b000, 32'h100, 32'h0);
        check_flags("bubble", 1'b0);
        tick(); check("bubble.pc", bus.pc, 32'h18); check_cnt("bubble", 7, 5);

        // Reset wins over a redirect in the same cycle
        bus.ex_valid = 1; rst = 1;
        tick();
        check("rst_redir.pc", bus.pc, 32'h0);
        check_cnt("rst_redir", 0, 0);
        rst = 0; bus.ex_valid = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end
endmodule
